// File: rtl/exp_pkg.sv
// Shared types and format helpers for the FP multiplier exponent path.
package exp_pkg;

    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        DENORM    = 3'd1,
        UNDERFLOW = 3'd2,
        OVERFLOW  = 3'd3,
        ZERO      = 3'd4,
        INF       = 3'd5,
        NAN       = 3'd6
    } exp_class_t;

    function automatic int bias(input bit is_double);
        return is_double ? 1023 : 127;
    endfunction

    function automatic int exponent_w(input bit is_double);
        return is_double ? 11 : 8;
    endfunction

    function automatic int mantissa_w(input bit is_double);
        return is_double ? 52 : 23;
    endfunction

endpackage

// File: rtl/exp_adder_pipe_if.sv
// Valid/ready bundle between operand capture, the exponent pipe and the mantissa stage.
interface exp_adder_pipe_if #(
    parameter bit IS_DOUBLE = 1'b0
);
    localparam int WIDTH      = IS_DOUBLE ? 64 : 32;
    localparam int EXPONENT_W = exp_pkg::exponent_w(IS_DOUBLE);
    localparam int MANTISSA_W = exp_pkg::mantissa_w(IS_DOUBLE);
    localparam int SHIFT_W    = $clog2(MANTISSA_W + 3);

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        op1;
    logic [WIDTH-1:0]        op2;
    logic                    out_valid;
    logic                    out_ready;
    logic                    res_sign;
    logic [EXPONENT_W-1:0]   res_exp;
    logic [EXPONENT_W+1:0]   res_sum;
    logic [SHIFT_W-1:0]      res_shift;
    exp_pkg::exp_class_t     res_class;
    logic                    imprecise;

    modport master (
        output in_valid, op1, op2, out_ready,
        input  in_ready, out_valid, res_sign, res_exp, res_sum, res_shift, res_class, imprecise
    );

    modport slave (
        input  in_valid, op1, op2, out_ready,
        output in_ready, out_valid, res_sign, res_exp, res_sum, res_shift, res_class, imprecise
    );
endinterface

// File: rtl/exp_classify.sv
// Stage-2 combinational classification of the widened signed exponent sum.
module exp_classify
    import exp_pkg::*;
#(
    parameter int EXPONENT_W = 8,
    parameter int MANTISSA_W = 23,
    parameter int SHIFT_W    = $clog2(MANTISSA_W + 3)
) (
    input  logic signed [EXPONENT_W+1:0] sum,
    output exp_class_t                   res_class,
    output logic [EXPONENT_W-1:0]        res_exp,
    output logic [SHIFT_W-1:0]           res_shift,
    output logic                         imprecise
);
    localparam int SUM_W = EXPONENT_W + 2;
    localparam logic signed [SUM_W-1:0] OVF_MIN   = SUM_W'((2 ** EXPONENT_W) - 1);
    localparam logic signed [SUM_W-1:0] ONE       = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] DEN_MIN   = SUM_W'(-MANTISSA_W);
    localparam logic [SHIFT_W-1:0]      UFL_SHIFT = SHIFT_W'(MANTISSA_W + 2);

    always_comb begin
        res_class = NORMAL;
        res_exp   = '0;
        res_shift = '0;
        imprecise = 1'b0;
        if (sum >= OVF_MIN) begin
            res_class = OVERFLOW;
            res_exp   = '1;
        end else if (sum >= ONE) begin
            res_exp = sum[EXPONENT_W-1:0];
        end else if (sum >= DEN_MIN) begin
            res_class = DENORM;
            res_shift = SHIFT_W'(ONE - sum);
        end else begin
            res_class = UNDERFLOW;
            res_shift = UFL_SHIFT;
            imprecise = 1'b1;
        end
    end
endmodule

// File: rtl/exp_adder_pipe.sv
// Two-stage valid/ready exponent pipe of the FP multiplier.
// Optional zero/Inf/NaN decode is enabled with `define EXP_ADD_SPECIALS_EN.
module exp_adder_pipe
    import exp_pkg::*;
#(
    parameter bit IS_DOUBLE = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    exp_adder_pipe_if.slave  bus
);
    localparam int WIDTH      = IS_DOUBLE ? 64 : 32;
    localparam int EXPONENT_W = exponent_w(IS_DOUBLE);
    localparam int MANTISSA_W = mantissa_w(IS_DOUBLE);
    localparam int SHIFT_W    = $clog2(MANTISSA_W + 3);
    localparam int SUM_W      = EXPONENT_W + 2;
    localparam int BIAS_V     = bias(IS_DOUBLE);

    logic adv1, adv2;
    logic v1, v2;

    logic [EXPONENT_W-1:0] e1_raw, e2_raw, e1_eff, e2_eff;
    logic                  special_in;
    exp_class_t            special_cls_in;

    logic                  s1_sign, s1_special;
    logic [EXPONENT_W-1:0] s1_e1, s1_e2;
    exp_class_t            s1_cls;

    assign adv2         = !v2 || bus.out_ready;
    assign adv1         = !v1 || adv2;
    assign bus.in_ready = adv1;

    assign e1_raw = bus.op1[WIDTH-2 -: EXPONENT_W];
    assign e2_raw = bus.op2[WIDTH-2 -: EXPONENT_W];
    // A zero exponent field is a denormal input whose effective exponent is 1.
    assign e1_eff = (e1_raw == '0) ? EXPONENT_W'(1) : e1_raw;
    assign e2_eff = (e2_raw == '0) ? EXPONENT_W'(1) : e2_raw;

`ifdef EXP_ADD_SPECIALS_EN
    logic nan1, nan2, inf1, inf2, zero1, zero2;
    logic frac1_nz, frac2_nz;

    assign frac1_nz = |bus.op1[MANTISSA_W-1:0];
    assign frac2_nz = |bus.op2[MANTISSA_W-1:0];
    assign nan1     = (e1_raw == '1) && frac1_nz;
    assign nan2     = (e2_raw == '1) && frac2_nz;
    assign inf1     = (e1_raw == '1) && !frac1_nz;
    assign inf2     = (e2_raw == '1) && !frac2_nz;
    assign zero1    = (e1_raw == '0) && !frac1_nz;
    assign zero2    = (e2_raw == '0) && !frac2_nz;

    always_comb begin
        special_in     = 1'b1;
        special_cls_in = ZERO;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            special_cls_in = NAN;
        end else if (inf1 || inf2) begin
            special_cls_in = INF;
        end else if (zero1 || zero2) begin
            special_cls_in = ZERO;
        end else begin
            special_in = 1'b0;
        end
    end
`else
    assign special_in     = 1'b0;
    assign special_cls_in = NORMAL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sign    <= 1'b0;
            s1_e1      <= '0;
            s1_e2      <= '0;
            s1_special <= 1'b0;
            s1_cls     <= NORMAL;
        end else if (adv1) begin
            v1         <= bus.in_valid;
            s1_sign    <= bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1];
            s1_e1      <= e1_eff;
            s1_e2      <= e2_eff;
            s1_special <= special_in;
            s1_cls     <= special_cls_in;
        end
    end

    logic signed [SUM_W-1:0] sum;
    exp_class_t              arith_cls, cls_n;
    logic [EXPONENT_W-1:0]   arith_exp, exp_n;
    logic [SHIFT_W-1:0]      arith_shift, shift_n;
    logic                    arith_imp, imp_n;

    assign sum = $signed({2'b00, s1_e1}) + $signed({2'b00, s1_e2}) - $signed(SUM_W'(BIAS_V));

    exp_classify #(
        .EXPONENT_W (EXPONENT_W),
        .MANTISSA_W (MANTISSA_W),
        .SHIFT_W    (SHIFT_W)
    ) u_classify (
        .sum       (sum),
        .res_class (arith_cls),
        .res_exp   (arith_exp),
        .res_shift (arith_shift),
        .imprecise (arith_imp)
    );

    // Special operands override the arithmetic class; res_sum still reports the raw sum.
    always_comb begin
        cls_n   = arith_cls;
        exp_n   = arith_exp;
        shift_n = arith_shift;
        imp_n   = arith_imp;
        if (s1_special) begin
            cls_n   = s1_cls;
            exp_n   = (s1_cls == ZERO) ? '0 : '1;
            shift_n = '0;
            imp_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2            <= 1'b0;
            bus.res_sign  <= 1'b0;
            bus.res_exp   <= '0;
            bus.res_sum   <= '0;
            bus.res_shift <= '0;
            bus.res_class <= NORMAL;
            bus.imprecise <= 1'b0;
        end else if (adv2) begin
            v2            <= v1;
            bus.res_sign  <= s1_sign;
            bus.res_exp   <= exp_n;
            bus.res_sum   <= sum;
            bus.res_shift <= shift_n;
            bus.res_class <= cls_n;
            bus.imprecise <= imp_n;
        end
    end

    assign bus.out_valid = v2;
endmodule

// File: tb/tb_exp_adder_pipe.sv
// Scoreboard bench for exp_adder_pipe: binary32 instance plus a binary64 spot check.
module tb_exp_adder_pipe;
    import exp_pkg::*;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [9:0] sum;
        logic [4:0] shift;
        logic [2:0] cls;
        logic       imp;
    } res_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    res_t sb_q[$];

    exp_adder_pipe_if #(.IS_DOUBLE(1'b0)) bus ();
    exp_adder_pipe_if #(.IS_DOUBLE(1'b1)) bus_d ();

    exp_adder_pipe #(.IS_DOUBLE(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    exp_adder_pipe #(.IS_DOUBLE(1'b1)) dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int   e1, e2, s;
        r  = '0;
        e1 = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        e2 = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        s  = e1 + e2 - 127;
        r.sign = a[31] ^ b[31];
        r.sum  = 10'(s);
        if (s >= 255) begin
            r.cls = OVERFLOW;
            r.exp = 8'hFF;
        end else if (s >= 1) begin
            r.cls = NORMAL;
            r.exp = 8'(s);
        end else if (s >= -23) begin
            r.cls   = DENORM;
            r.shift = 5'(1 - s);
        end else begin
            r.cls   = UNDERFLOW;
            r.shift = 5'd25;
            r.imp   = 1'b1;
        end
`ifdef EXP_ADD_SPECIALS_EN
        begin
            logic an, bn, ai, bi, az, bz;
            an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
            bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
            ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
            bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
            az = (a[30:0] == 0);
            bz = (b[30:0] == 0);
            if (an || bn || (ai && bz) || (az && bi)) begin
                r.cls = NAN; r.exp = 8'hFF; r.shift = 0; r.imp = 0;
            end else if (ai || bi) begin
                r.cls = INF; r.exp = 8'hFF; r.shift = 0; r.imp = 0;
            end else if (az || bz) begin
                r.cls = ZERO; r.exp = 8'h00; r.shift = 0; r.imp = 0;
            end
        end
`endif
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.res_sign, bus.res_exp, bus.res_sum, bus.res_shift, 3'(bus.res_class), bus.imprecise};
    endfunction

    task automatic test_reset();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        total++;
        if (observed() !== res_t'(0)) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", observed());
        end
    endtask

    task automatic test_latency();
        res_t want;
        want = model(32'h3F800000, 32'h3F800000);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op1       = 32'h3F800000;
        bus.op2       = 32'h3F800000;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL lat_accept: in_ready=%b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_cycle1: out_valid=%b want 0", bus.out_valid);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || observed() !== want) begin
            bad++;
            $display("FAIL lat_cycle2: valid=%b got %h want %h", bus.out_valid, observed(), want);
        end
    endtask

    task automatic test_arith();
        logic [31:0] a[$];
        logic [31:0] b[$];
        int sent = 0, got = 0, cyc = 0;
        res_t want;
        a = '{32'h3F800000, 32'h71800000, 32'h1C800000, 32'h00800000, 32'hBF800000,
              32'h7F000000, 32'h7F000000, 32'h1F800000, 32'h1A000000, 32'h1A000000, 32'h00000001};
        b = '{32'h3F800000, 32'h71800000, 32'h21800000, 32'h00800000, 32'h3F800000,
              32'h3F800000, 32'h40000000, 32'h20000000, 32'h1A000000, 32'h19800000, 32'h3F800000};
        while (got < a.size() && cyc < 200) begin
            @(negedge clk);
            bus.out_ready = (cyc % 3) != 2;
            bus.in_valid  = sent < a.size();
            if (sent < a.size()) begin
                bus.op1 = a[sent];
                bus.op2 = b[sent];
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL arith_extra: unexpected result %h", observed());
                end else begin
                    want = sb_q.pop_front();
                    if (observed() !== want) begin
                        bad++;
                        $display("FAIL arith_%0d: got %h want %h", got, observed(), want);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(a[sent], b[sent]));
                sent++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (cyc >= 200) begin
            total++;
            bad++;
            $display("FAIL arith_timeout: got %0d results want %0d", got, a.size());
        end
    endtask

    task automatic test_specials();
        logic [31:0] a[$];
        logic [31:0] b[$];
        res_t want;
        a = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
        b = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h3F800000};
        for (int i = 0; i < a.size(); i++) begin
            int wait_cyc = 0;
            want = model(a[i], b[i]);
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.op1       = a[i];
            bus.op2       = b[i];
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            while (!bus.out_valid && wait_cyc < 5) begin
                @(negedge clk);
                #1;
                wait_cyc++;
            end
            total++;
            if (bus.out_valid !== 1'b1 || observed() !== want) begin
                bad++;
                $display("FAIL special_%0d: valid=%b got %h want %h", i, bus.out_valid, observed(), want);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[4];
        logic [31:0] b[4];
        int sent = 0, got = 0, cyc = 0;
        logic have_snap = 1'b0;
        res_t snap, want;
        a = '{32'h3F800000, 32'h71800000, 32'h1C800000, 32'h00800000};
        b = '{32'h40000000, 32'h71800000, 32'h21800000, 32'h00800000};
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            bus.out_ready = cyc >= 5;
            bus.in_valid  = sent < 4;
            if (sent < 4) begin
                bus.op1 = a[sent];
                bus.op2 = b[sent];
            end
            #1;
            if (cyc == 2) begin
                total++;
                if (bus.in_ready !== 1'b0 || sent != 2) begin
                    bad++;
                    $display("FAIL b2b_backpressure: in_ready=%b accepted=%0d want 0/2", bus.in_ready, sent);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (have_snap) begin
                    total++;
                    if (observed() !== snap) begin
                        bad++;
                        $display("FAIL b2b_stable: got %h want %h", observed(), snap);
                    end
                end else begin
                    snap      = observed();
                    have_snap = 1'b1;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                want = (sb_q.size() != 0) ? sb_q.pop_front() : res_t'('1);
                if (observed() !== want) begin
                    bad++;
                    $display("FAIL b2b_order_%0d: got %h want %h", got, observed(), want);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(a[sent], b[sent]));
                sent++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (cyc >= 60) begin
            total++;
            bad++;
            $display("FAIL b2b_timeout: got %0d results want 4", got);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op1       = 32'h3F800000;
        bus.op2       = 32'h3F800000;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: out_valid=%b want 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== res_t'(0)) begin
            bad++;
            $display("FAIL midrst_clear: out_valid=%b in_ready=%b res=%h want 0/1/0",
                     bus.out_valid, bus.in_ready, observed());
        end
        sb_q.delete();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_double();
        int wait_cyc = 0;
        @(negedge clk);
        bus_d.out_ready = 1'b1;
        bus_d.in_valid  = 1'b1;
        bus_d.op1       = 64'h3FF0000000000000;
        bus_d.op2       = 64'h3FF0000000000000;
        @(negedge clk);
        bus_d.in_valid = 1'b0;
        #1;
        while (!bus_d.out_valid && wait_cyc < 5) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        total++;
        if (bus_d.out_valid !== 1'b1 || bus_d.res_exp !== 11'd1023 || bus_d.res_sum !== 13'd1023
            || bus_d.res_class !== NORMAL || bus_d.res_shift !== 6'd0) begin
            bad++;
            $display("FAIL double_normal: valid=%b exp=%0d sum=%0d class=%0d want 1/1023/1023/0",
                     bus_d.out_valid, bus_d.res_exp, bus_d.res_sum, bus_d.res_class);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.op1         = '0;
        bus.op2         = '0;
        bus.out_ready   = 1'b1;
        bus_d.in_valid  = 1'b0;
        bus_d.op1       = '0;
        bus_d.op2       = '0;
        bus_d.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_latency();
        test_arith();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        test_double();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
